// File: rtl/simon_input_checker.sv
`default_nettype none
// ============================================================================
//  Module   : simon_input_checker
//  Purpose  : Pulls expected colors from the pattern shifter, checks each
//             debounced button press against them and reports pass/fail.
//  Revision : 1.0
// ============================================================================
module simon_input_checker #(
    parameter int N_COLORS    = 2,
    parameter int LEN_W       = 2,
    parameter int TIMEOUT     = 50_000_000,
    parameter int RELEASE_CYC = 500_000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] round_len,
    input  logic [1:0]       compare,
    input  logic [3:0]       btn,
    output logic             next,
    output logic             pass,
    output logic             fail,
    output logic             busy
);

    localparam int c_TMR_MAX = (TIMEOUT > RELEASE_CYC) ? TIMEOUT : RELEASE_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_REL_LAST = c_TMR_W'(RELEASE_CYC - 1);
    localparam logic [LEN_W-1:0]   c_LEN_MAX  = LEN_W'(N_COLORS);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_SETTLE  = 3'd2;
    localparam logic [2:0] c_ST_WAIT    = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;
    localparam logic [2:0] c_ST_PASS    = 3'd5;
    localparam logic [2:0] c_ST_FAIL    = 3'd6;

    logic [3:0]         r_btn_m;
    logic [3:0]         r_btn_s;
    logic [3:0]         r_btn_p;
    logic [2:0]         r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [1:0]         r_expected;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_next;
    logic               r_pass;
    logic               r_fail;
    logic               r_busy;

    logic               w_press;
    logic               w_onehot;
    logic [1:0]         w_btn_color;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [2:0]         w_state_nxt;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic [1:0]         w_expected_nxt;
    logic [c_TMR_W-1:0] w_timer_nxt;

    assign w_press       = (r_btn_s != 4'd0) && (r_btn_p == 4'd0);
    assign w_onehot      = ((r_btn_s & (r_btn_s - 4'd1)) == 4'd0);
    assign w_len_clamped = (round_len > c_LEN_MAX) ? c_LEN_MAX : round_len;

    always_comb begin
        w_btn_color = 2'd0;
        case (r_btn_s)
            4'b0010: w_btn_color = 2'd1;
            4'b0100: w_btn_color = 2'd2;
            4'b1000: w_btn_color = 2'd3;
            default: w_btn_color = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_expected_nxt  = r_expected;
        w_timer_nxt     = r_timer;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (round_len == '0) begin
                        w_state_nxt = c_ST_PASS;
                    end else begin
                        w_remaining_nxt = w_len_clamped;
                        w_state_nxt     = c_ST_FETCH;
                    end
                end
            end
            c_ST_FETCH: w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: begin
                w_expected_nxt = compare;
                w_timer_nxt    = '0;
                w_state_nxt    = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A press on the deadline cycle still counts as in time.
                if (w_press) begin
                    if (w_onehot && (w_btn_color == r_expected)) begin
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                        w_timer_nxt     = '0;
                        w_state_nxt     = c_ST_RELEASE;
                    end else begin
                        w_state_nxt = c_ST_FAIL;
                    end
                end else if (r_timer == c_TMO_LAST) begin
                    w_state_nxt = c_ST_FAIL;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end
            c_ST_RELEASE: begin
                if (r_btn_s != 4'd0) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_REL_LAST) begin
                    w_state_nxt = (r_remaining == '0) ? c_ST_PASS : c_ST_FETCH;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end
            c_ST_PASS: w_state_nxt = c_ST_IDLE;
            c_ST_FAIL: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_btn_m     <= '0;
            r_btn_s     <= '0;
            r_btn_p     <= '0;
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_expected  <= '0;
            r_timer     <= '0;
            r_next      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_btn_m     <= btn;
            r_btn_s     <= r_btn_m;
            r_btn_p     <= r_btn_s;
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_expected  <= w_expected_nxt;
            r_timer     <= w_timer_nxt;
            // Outputs track the state being entered so they align with it.
            r_next      <= (w_state_nxt == c_ST_FETCH);
            r_pass      <= (w_state_nxt == c_ST_PASS);
            r_fail      <= (w_state_nxt == c_ST_FAIL);
            r_busy      <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign next = r_next;
    assign pass = r_pass;
    assign fail = r_fail;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_simon_input_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_input_checker
//  Purpose  : Self-checking bench: directed and random rounds against a
//             schedule-level model of the checker's round timing.
//  Revision : 1.0
// ============================================================================
module tb_simon_input_checker;

    localparam int c_TIMEOUT = 100;
    localparam int c_REL     = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] round_len;
    logic [1:0] compare;
    logic [3:0] btn;
    logic       next;
    logic       pass;
    logic       fail;
    logic       busy;

    simon_input_checker #(
        .N_COLORS    (2),
        .LEN_W       (2),
        .TIMEOUT     (c_TIMEOUT),
        .RELEASE_CYC (c_REL)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .round_len (round_len),
        .compare   (compare),
        .btn       (btn),
        .next      (next),
        .pass      (pass),
        .fail      (fail),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor plus a shifter stand-in that serves colors on next.
    int         next_q[$];
    int         pass_q[$];
    int         fail_q[$];
    logic [1:0] col_q[$];
    bit         cmp_hold = 1'b0;

    always @(negedge clk) begin
        if (next) next_q.push_back(cyc);
        if (pass) pass_q.push_back(cyc);
        if (fail) fail_q.push_back(cyc);
        chk("exclusive_outputs", 64'($countones({next, pass, fail}) > 1), 64'd0);
        if (next) begin
            compare  = (col_q.size() > 0) ? col_q.pop_front() : 2'($urandom);
            cmp_hold = 1'b1;
        end else if (cmp_hold) begin
            cmp_hold = 1'b0;
        end else begin
            compare = 2'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    // Round description: act 0=correct, 1=wrong one-hot, 2=multi-press, 3=no press.
    int         g_len;
    logic [1:0] g_col[2];
    int         g_act[2];
    int         g_dly[2];
    int         g_rel[2];
    int         g_bk[2];
    int         g_wk[2];
    logic [3:0] g_mp[2];
    bit         g_hold_wrong;
    bit         g_busy_start;

    task automatic cfg(input int len, input int a0, input int a1, input int d0, input int d1);
        g_len = len;
        g_act[0] = a0; g_act[1] = a1;
        g_dly[0] = d0; g_dly[1] = d1;
        for (int i = 0; i < 2; i++) begin
            g_col[i] = 2'($urandom);
            g_rel[i] = 1 + int'($urandom_range(3));
            g_bk[i]  = 0;
            g_wk[i]  = 1 + int'($urandom_range(2));
            do g_mp[i] = 4'($urandom); while ($countones(g_mp[i]) < 2);
        end
        g_hold_wrong = 1'b0;
        g_busy_start = 1'b0;
    endtask

    task automatic run_round();
        int eff, n, p, r, t_end, exp_pass, exp_fail;
        int exp_next[$];
        logic [3:0] pat;
        bit done;
        next_q.delete(); pass_q.delete(); fail_q.delete(); col_q.delete();
        eff = (g_len > 2) ? 2 : g_len;
        for (int i = 0; i < eff; i++) col_q.push_back(g_col[i]);
        exp_pass = -1; exp_fail = -1; done = 1'b0; t_end = 0;
        if (g_hold_wrong) begin
            btn = 4'(1 << ((int'(g_col[0]) + 1) % 4));
            repeat (4) step();
        end
        start = 1'b1; round_len = 2'(g_len);
        step();
        start = 1'b0; round_len = 2'($urandom);
        n = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (eff == 0) begin
            exp_pass = n; t_end = n;
        end
        for (int i = 0; i < eff && !done; i++) begin
            exp_next.push_back(n);
            if (i == 0 && g_busy_start) begin
                step_to(n + 3);
                start = 1'b1; round_len = 2'd0;
                step();
                start = 1'b0;
            end
            if (i == 0 && g_hold_wrong) begin
                step_to(n + 2);
                btn = 4'd0;
                p = n + 7;
            end else begin
                p = n + g_dly[i];
            end
            if (g_act[i] == 3) begin
                exp_fail = n + 2 + c_TIMEOUT; t_end = exp_fail; done = 1'b1;
            end else begin
                step_to(p);
                if (g_act[i] == 0)      pat = 4'(1 << g_col[i]);
                else if (g_act[i] == 1) pat = 4'(1 << ((int'(g_col[i]) + g_wk[i]) % 4));
                else                    pat = g_mp[i];
                btn = pat;
                if (g_act[i] != 0) begin
                    exp_fail = p + 3; t_end = exp_fail; done = 1'b1;
                    step_to(p + 2);
                    btn = 4'd0;
                end else begin
                    r = p + g_rel[i];
                    step_to(r);
                    btn = 4'd0;
                    if (g_bk[i] != 0) begin
                        step_to(r + g_bk[i]);
                        btn = pat;
                        step();
                        btn = 4'd0;
                        r = r + g_bk[i] + 1;
                    end
                    n = r + 2 + c_REL;
                    if (i == eff - 1) begin
                        exp_pass = n; t_end = n;
                    end
                end
            end
        end
        step_to(t_end);
        chk("busy_at_end", 64'(busy), 64'd1);
        step();
        chk("busy_after_end", 64'(busy), 64'd0);
        repeat (3) step();
        chk("next_count", 64'(next_q.size()), 64'(exp_next.size()));
        for (int k = 0; k < exp_next.size() && k < next_q.size(); k++)
            chk("next_cycle", 64'(next_q[k]), 64'(exp_next[k]));
        chk("pass_count", 64'(pass_q.size()), 64'(exp_pass >= 0));
        if (exp_pass >= 0 && pass_q.size() > 0) chk("pass_cycle", 64'(pass_q[0]), 64'(exp_pass));
        chk("fail_count", 64'(fail_q.size()), 64'(exp_fail >= 0));
        if (exp_fail >= 0 && fail_q.size() > 0) chk("fail_cycle", 64'(fail_q[0]), 64'(exp_fail));
    endtask

    initial begin
        int t0, sel;
        resetn = 1'b0; start = 1'b0; round_len = 2'd0; btn = 4'd0;
        repeat (3) step();
        chk("reset_next", 64'(next), 64'd0);
        chk("reset_pass", 64'(pass), 64'd0);
        chk("reset_fail", 64'(fail), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        repeat (2) step();

        // Two-color pass: 01 then 11.
        cfg(2, 0, 0, 3, 5);
        g_col[0] = 2'd1; g_col[1] = 2'd3;
        run_round();

        // Wrong color: expected 10, press 0001.
        cfg(2, 1, 0, 2, 0);
        g_col[0] = 2'd2; g_wk[0] = 2;
        run_round();

        // Multi-press: expected 00, press 0011.
        cfg(1, 2, 0, 4, 0);
        g_col[0] = 2'd0; g_mp[0] = 4'b0011;
        run_round();

        // Timeout with no press, then a press on the last allowed cycle.
        cfg(1, 3, 0, 0, 0);
        run_round();
        cfg(1, 0, 0, c_TIMEOUT - 1, 0);
        run_round();

        // Zero-length round.
        cfg(0, 0, 0, 0, 0);
        run_round();

        // Start while busy is ignored.
        cfg(1, 0, 0, 10, 0);
        g_busy_start = 1'b1;
        run_round();

        // Button held across FETCH produces no event.
        cfg(2, 0, 0, 0, 2);
        g_hold_wrong = 1'b1;
        run_round();

        // Length 3 clamps to 2, with release bounce.
        cfg(3, 0, 0, 1, 6);
        g_bk[0] = 2;
        run_round();

        // Reset mid-WAIT_PRESS abandons the round.
        next_q.delete(); pass_q.delete(); fail_q.delete(); col_q.delete();
        col_q.push_back(2'd1); col_q.push_back(2'd2);
        start = 1'b1; round_len = 2'd2;
        step();
        start = 1'b0;
        t0 = cyc;
        step_to(t0 + 5);
        resetn = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_next", 64'(next), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        next_q.delete(); pass_q.delete(); fail_q.delete();
        repeat (c_TIMEOUT + 10) step();
        chk("rst_no_pass", 64'(pass_q.size()), 64'd0);
        chk("rst_no_fail", 64'(fail_q.size()), 64'd0);
        chk("rst_held_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        col_q.delete();
        repeat (2) step();
        cfg(1, 0, 0, 4, 0);
        run_round();

        // Random rounds.
        for (int k = 0; k < 30; k++) begin
            cfg(int'($urandom_range(3)), 0, 0, int'($urandom_range(20)), int'($urandom_range(20)));
            for (int i = 0; i < 2; i++) begin
                sel = int'($urandom_range(9));
                g_act[i] = (sel < 6) ? 0 : sel - 5;
                if (g_act[i] > 3) g_act[i] = 0;
                g_bk[i] = int'($urandom_range(3));
            end
            run_round();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
